// File: rtl/tile_walker_pkg.sv
// Shared types and default geometry for the tile walker.
// Modules re-derive T and STEP from their own parameters.
package tile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WALK = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int TILE_LOG2_DEF = 4;
    localparam int COORD_W_DEF   = 10;
    localparam int LANES_DEF     = 2;

    localparam int T    = 1 << TILE_LOG2_DEF;
    localparam int STEP = LANES_DEF * T;

    // Widths of the lane mask and of the overflow-safe coordinate arithmetic.
    localparam int MASK_W  = LANES_DEF;
    localparam int ARITH_W = COORD_W_DEF + 1;

endpackage

// File: rtl/tile_walker_if.sv
// Box request and tile-beat output bundle of the tile walker.
// A beat moves on a cycle where out_valid && out_ready; an unaccepted beat holds
// x, y and mask stable, and out_valid only drops without a transfer on abort.
interface tile_walker_if #(
    parameter int COORD_W = 10,
    parameter int LANES   = 2
);
    logic               start;
    logic               abort;
    logic [COORD_W-1:0] min_x;
    logic [COORD_W-1:0] min_y;
    logic [COORD_W-1:0] max_x;
    logic [COORD_W-1:0] max_y;
    logic               out_ready;
    logic               out_valid;
    logic [COORD_W-1:0] out_tile_x;
    logic [COORD_W-1:0] out_tile_y;
    logic [LANES-1:0]   out_lane_mask;
    logic               busy;
    logic               done;

    modport master (
        output start, abort, min_x, min_y, max_x, max_y, out_ready,
        input  out_valid, out_tile_x, out_tile_y, out_lane_mask, busy, done
    );

    modport slave (
        input  start, abort, min_x, min_y, max_x, max_y, out_ready,
        output out_valid, out_tile_x, out_tile_y, out_lane_mask, busy, done
    );
endinterface

// File: rtl/tile_walker_bbox_setup.sv
// Combinational box conditioning: tile-align the corners, clamp the far corner
// to the screen and flag boxes that cover no on-screen tile.
module tile_bbox_setup
    import tile_pkg::*;
#(
    parameter int TILE_LOG2 = TILE_LOG2_DEF,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int SCREEN_W  = 1024,
    parameter int SCREEN_H  = 1024
) (
    input  logic [COORD_W-1:0] i_min_x,
    input  logic [COORD_W-1:0] i_min_y,
    input  logic [COORD_W-1:0] i_max_x,
    input  logic [COORD_W-1:0] i_max_y,
    output logic [COORD_W:0]   o_ax0,
    output logic [COORD_W:0]   o_ay0,
    output logic [COORD_W:0]   o_ax1,
    output logic [COORD_W:0]   o_ay1,
    output logic               o_empty
);
    localparam int W1 = COORD_W + 1;
    localparam logic [W1-1:0] ALIGN_MASK = ~W1'((1 << TILE_LOG2) - 1);
    localparam logic [W1-1:0] SCR_W      = W1'(SCREEN_W);
    localparam logic [W1-1:0] SCR_H      = W1'(SCREEN_H);
    localparam logic [W1-1:0] X_LAST     = W1'(SCREEN_W - 1);
    localparam logic [W1-1:0] Y_LAST     = W1'(SCREEN_H - 1);

    logic [W1-1:0] w_min_x;
    logic [W1-1:0] w_min_y;
    logic [W1-1:0] w_max_x;
    logic [W1-1:0] w_max_y;
    logic [W1-1:0] w_cmx;
    logic [W1-1:0] w_cmy;

    assign w_min_x = {1'b0, i_min_x};
    assign w_min_y = {1'b0, i_min_y};
    assign w_max_x = {1'b0, i_max_x};
    assign w_max_y = {1'b0, i_max_y};

    assign w_cmx = (w_max_x > X_LAST) ? X_LAST : w_max_x;
    assign w_cmy = (w_max_y > Y_LAST) ? Y_LAST : w_max_y;

    assign o_ax0 = w_min_x & ALIGN_MASK;
    assign o_ay0 = w_min_y & ALIGN_MASK;
    assign o_ax1 = w_cmx & ALIGN_MASK;
    assign o_ay1 = w_cmy & ALIGN_MASK;

    // Inverted corners use the raw inputs; the clamp only limits the far edge.
    assign o_empty = (w_min_x > w_max_x) || (w_min_y > w_max_y) ||
                     (w_min_x >= SCR_W)  || (w_min_y >= SCR_H);
endmodule

// File: rtl/tile_walker.sv
// Row-major tile walker: emits LANES adjacent tiles per beat over a clamped,
// tile-aligned bounding box with ready/valid backpressure.
module tile_walker
    import tile_pkg::*;
#(
    parameter int TILE_LOG2 = TILE_LOG2_DEF,
    parameter int COORD_W   = COORD_W_DEF,
    parameter int LANES     = LANES_DEF,
    parameter int SCREEN_W  = 1024,
    parameter int SCREEN_H  = 1024
) (
    input  logic         clk,
    input  logic         rst,
    tile_walker_if.slave bus,
    output state_t       o_state
);
    localparam int W1 = COORD_W + 1;
    localparam logic [W1-1:0] TILE_T    = W1'(1 << TILE_LOG2);
    localparam logic [W1-1:0] TILE_STEP = W1'(LANES * (1 << TILE_LOG2));

    logic [W1-1:0] w_ax0;
    logic [W1-1:0] w_ay0;
    logic [W1-1:0] w_ax1;
    logic [W1-1:0] w_ay1;
    logic          w_empty;

    tile_bbox_setup #(
        .TILE_LOG2 (TILE_LOG2),
        .COORD_W   (COORD_W),
        .SCREEN_W  (SCREEN_W),
        .SCREEN_H  (SCREEN_H)
    ) u_setup (
        .i_min_x (bus.min_x),
        .i_min_y (bus.min_y),
        .i_max_x (bus.max_x),
        .i_max_y (bus.max_y),
        .o_ax0   (w_ax0),
        .o_ay0   (w_ay0),
        .o_ax1   (w_ax1),
        .o_ay1   (w_ay1),
        .o_empty (w_empty)
    );

    state_t        r_state;
    state_t        w_state_nxt;
    logic [W1-1:0] r_x;
    logic [W1-1:0] r_y;
    logic [W1-1:0] r_ax0;
    logic [W1-1:0] r_ax1;
    logic [W1-1:0] r_ay1;
    logic [W1-1:0] w_x_nxt;
    logic [W1-1:0] w_y_nxt;
    logic [W1-1:0] w_x_step;
    logic [W1-1:0] w_y_step;
    logic          w_latch;
    logic [LANES-1:0] w_mask;

    // One spare bit keeps x+STEP and y+T from wrapping past the last coordinate.
    assign w_x_step = r_x + TILE_STEP;
    assign w_y_step = r_y + TILE_T;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_latch     = 1'b0;
        if (bus.abort) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        w_latch     = 1'b1;
                        w_x_nxt     = w_ax0;
                        w_y_nxt     = w_ay0;
                        w_state_nxt = w_empty ? ST_DONE : ST_WALK;
                    end
                end
                ST_WALK: begin
                    if (bus.out_ready) begin
                        if (w_x_step <= r_ax1) begin
                            w_x_nxt = w_x_step;
                        end else if (w_y_step <= r_ay1) begin
                            w_x_nxt = r_ax0;
                            w_y_nxt = w_y_step;
                        end else begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
                ST_DONE: w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_x   <= '0;
            r_y   <= '0;
            r_ax0 <= '0;
            r_ax1 <= '0;
            r_ay1 <= '0;
        end else begin
            r_x <= w_x_nxt;
            r_y <= w_y_nxt;
            if (w_latch) begin
                r_ax0 <= w_ax0;
                r_ax1 <= w_ax1;
                r_ay1 <= w_ay1;
            end
        end
    end

    always_comb begin
        w_mask = '0;
        for (int i = 0; i < LANES; i++) begin
            w_mask[i] = (r_x + W1'(i * (1 << TILE_LOG2))) <= r_ax1;
        end
    end

    assign bus.out_valid     = (r_state == ST_WALK);
    assign bus.out_tile_x    = r_x[COORD_W-1:0];
    assign bus.out_tile_y    = r_y[COORD_W-1:0];
    assign bus.out_lane_mask = (r_state == ST_WALK) ? w_mask : '0;
    assign bus.busy          = (r_state != ST_IDLE);
    assign bus.done          = (r_state == ST_DONE);
    assign o_state           = r_state;
endmodule
